// File: rtl/memoria_de_dados_param.sv
// Parametrised word-addressed data RAM with per-byte write enables, req/ready/ack handshake
// and configurable read latency. Define MEM_BOUNDS_CHECK_EN to flag and suppress addr >= DEPTH.
module memoria_de_dados_param #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 32,
   parameter int DEPTH        = 2048,
   parameter int READ_LATENCY = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req,
   input  logic                      we,
   input  logic [DATA_WIDTH/8-1:0]   be,
   input  logic [ADDR_WIDTH-1:0]     addr,
   input  logic [DATA_WIDTH-1:0]     datain,
   output logic                      ready,
   output logic                      ack,
   output logic [DATA_WIDTH-1:0]     dataout,
   output logic                      fault
);

   localparam int BYTE_LANES = DATA_WIDTH / 8;
   localparam int IDX_W      = $clog2(DEPTH);
   localparam int CNT_W      = 3;

   if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
      $error("memoria_de_dados_param: READ_LATENCY must be within 1..4");
   end
   if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
      $error("memoria_de_dados_param: DATA_WIDTH must be a multiple of 8");
   end

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   state_t                 state_r;
   state_t                 state_nx_s;
   logic [CNT_W-1:0]       cnt_r;
   logic [CNT_W-1:0]       cnt_nx_s;
   logic [IDX_W-1:0]       idx_s;
   logic [IDX_W-1:0]       idx_r;
   logic                   oor_s;
   logic                   oor_r;
   logic                   accept_s;
   logic                   wr_en_s;
   logic                   ld_rd_s;
   logic                   ack_nx_s;
   logic                   dout_ld_s;
   logic                   flt_s;
   logic [IDX_W-1:0]       dout_idx_s;
   logic                   ack_r;
   logic [DATA_WIDTH-1:0]  dataout_r;
   logic [DATA_WIDTH-1:0]  mem_r [DEPTH];

   function automatic logic [DATA_WIDTH-1:0] merge_lanes(
      input logic [DATA_WIDTH-1:0] old_w,
      input logic [DATA_WIDTH-1:0] new_w,
      input logic [BYTE_LANES-1:0] lanes
   );
      logic [DATA_WIDTH-1:0] res;
      res = old_w;
      for (int i = 0; i < BYTE_LANES; i++) begin
         if (lanes[i]) begin
            res[8*i +: 8] = new_w[8*i +: 8];
         end else begin
            res[8*i +: 8] = old_w[8*i +: 8];
         end
      end
      return res;
   endfunction

   assign idx_s    = addr[IDX_W-1:0];
   assign ready    = (state_r == ST_IDLE);
   assign accept_s = req && (state_r == ST_IDLE);

`ifdef MEM_BOUNDS_CHECK_EN
   assign oor_s = (addr >= ADDR_WIDTH'(DEPTH));
`else
   // Upper address bits only feed the bounds check, so they are deliberately dropped here.
   assign oor_s = 1'b0;
   if (ADDR_WIDTH > IDX_W) begin : g_unused_hi
      logic unused_addr_hi_s;
      assign unused_addr_hi_s = ^addr[ADDR_WIDTH-1:IDX_W];
   end
`endif

   // Next-state and per-edge datapath controls for the IDLE/WAIT handshake
   always_comb begin
      state_nx_s = state_r;
      cnt_nx_s   = cnt_r;
      wr_en_s    = 1'b0;
      ld_rd_s    = 1'b0;
      ack_nx_s   = 1'b0;
      dout_ld_s  = 1'b0;
      flt_s      = 1'b0;
      dout_idx_s = idx_s;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               if (we) begin
                  wr_en_s  = ~oor_s;
                  ack_nx_s = 1'b1;
                  flt_s    = oor_s;
               end else if (READ_LATENCY == 1) begin
                  ack_nx_s  = 1'b1;
                  dout_ld_s = 1'b1;
                  flt_s     = oor_s;
               end else begin
                  ld_rd_s    = 1'b1;
                  state_nx_s = ST_WAIT;
                  cnt_nx_s   = CNT_W'(READ_LATENCY - 1);
               end
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            cnt_nx_s   = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            dout_idx_s = idx_r;
            if (cnt_r == {{(CNT_W-1){1'b0}}, 1'b1}) begin
               state_nx_s = ST_IDLE;
               ack_nx_s   = 1'b1;
               dout_ld_s  = 1'b1;
               flt_s      = oor_r;
            end else begin
               state_nx_s = ST_WAIT;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
            cnt_nx_s   = {CNT_W{1'b0}};
         end
      endcase
   end

   // State, wait counter and the read context held across WAIT
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
         cnt_r   <= {CNT_W{1'b0}};
         idx_r   <= {IDX_W{1'b0}};
         oor_r   <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         cnt_r   <= cnt_nx_s;
         if (ld_rd_s) begin
            idx_r <= idx_s;
            oor_r <= oor_s;
         end
      end
   end

   // Registered completion pulse and read data (held until the next read completes)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ack_r     <= 1'b0;
         dataout_r <= {DATA_WIDTH{1'b0}};
      end else begin
         ack_r <= ack_nx_s;
         if (dout_ld_s) begin
            dataout_r <= flt_s ? {DATA_WIDTH{1'b0}} : mem_r[dout_idx_s];
         end
      end
   end

   // RAM array: contents survive reset, writes commit at the accepting edge
   always_ff @(posedge clk) begin
      if (wr_en_s && !rst) begin
         mem_r[idx_s] <= merge_lanes(mem_r[idx_s], datain, be);
      end
   end

`ifdef MEM_BOUNDS_CHECK_EN
   logic fault_r;

   // Fault flag rides with ack for exactly one cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fault_r <= 1'b0;
      end else begin
         fault_r <= ack_nx_s & flt_s;
      end
   end

   assign fault = fault_r;
`else
   assign fault = 1'b0;
`endif

   assign ack     = ack_r;
   assign dataout = dataout_r;

endmodule

// File: doc/memoria_de_dados_param.md
Name: memoria_de_dados_param

Overview:
- Parametrised successor to the single-port CPU data memory.
- Word-addressed synchronous RAM on one clock, configurable data width, depth and read latency.
- Adds per-byte write enables, a req/ready/ack handshake, wait states and an optional out-of-range fault.
- Sits between the CPU load/store stage and the RAM array.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 32, width of the addr port.
- DEPTH, 2048, number of words.
- READ_LATENCY, 1, read wait cycles, legal range 1..4.
- Derived localparams, not overridable:
  - BYTE_LANES = DATA_WIDTH/8.
  - IDX_W = clog2(DEPTH).

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- req, input, 1, request valid; held by the master until accepted.
- we, input, 1, 1 = write, 0 = read; sampled with req.
- be, input, BYTE_LANES, byte write enables; bit i controls datain[8i+7:8i]; ignored on reads.
- addr, input, ADDR_WIDTH, word address.
- datain, input, DATA_WIDTH, write data.
- ready, output, 1, block can accept a request this cycle.
- ack, output, 1, one-cycle completion pulse.
- dataout, output, DATA_WIDTH, read data; valid when ack=1 on a read.
- fault, output, 1, out-of-range flag; qualified by ack.

Behaviour:
- Reset, async, immediate:
  - ack=0, dataout=0, fault=0, wait counter=0, state=IDLE, so ready=1.
  - RAM contents are not reset.
- Acceptance: on a rising edge where req=1 and ready=1 (the accepting edge E0). With ready=0, req is ignored and nothing is latched.
- Index = addr[IDX_W-1:0]. Upper address bits only matter for the fault check.
- States are IDLE and WAIT. ready=1 exactly when state=IDLE. ready is combinational from state.
- Write:
  - At E0, lanes with be[i]=1 are written; other lanes are preserved.
  - ack=1 is registered at E0 and is high for the following cycle.
  - State stays IDLE, so back-to-back writes sustain one per cycle.
  - be=0 still acks, with no RAM change.
  - dataout is unchanged by writes.
- Read, READ_LATENCY=1:
  - RAM is read at E0; dataout and ack=1 are registered at E0.
  - State stays IDLE, giving one read per cycle.
- Read, READ_LATENCY=L>1:
  - At E0, index is latched, counter is loaded with L-1, state goes to WAIT, ready=0.
  - Counter decrements each edge.
  - On edge E0+L-1 (counter reaching 0): dataout is loaded from the latched index, ack=1, state returns to IDLE.
  - A new request can be accepted in the ack cycle.
- ack is a pulse. It is cleared on any edge that does not complete a transaction.
- dataout holds its last read value until the next read completes.
- Read-after-write to the same word returns the new data, because the write commits at its accepting edge.
- Only one transaction is in flight, so no same-edge read/write collision exists.
- Reset mid-WAIT: the read is aborted and no ack is produced. A write accepted before reset stays committed.
- Illegal READ_LATENCY, outside 1..4, is a static elaboration error, raised via a generate-time check.

Optional Feature:
- Macro: MEM_BOUNDS_CHECK_EN.
- Defined:
  - Any request with addr >= DEPTH is still accepted with normal timing.
  - Writes are suppressed.
  - Reads return dataout=0.
  - fault=1 together with ack, for that single cycle only.
  - fault=0 otherwise.
- Undefined:
  - fault is tied to 0.
  - Addresses wrap modulo 2^IDX_W and access RAM[addr[IDX_W-1:0]].

Test Plan:
1. Defaults. Write addr=5, datain=0xDEADBEEF, be=4'hF, then read addr=5 next cycle -> ack on each; read dataout=0xDEADBEEF one cycle after read acceptance; ready stays 1 throughout.
2. Byte enables. Write 0x11223344 be=F to addr 9, then 0xAABBCCDD be=4'b0101, then read -> dataout=0x11BB33DD.
3. READ_LATENCY=3. Read addr 9 -> ready=0 for 2 cycles after E0; ack and dataout valid in the 3rd cycle; a req held during WAIT is accepted only once ready returns to 1.
4. Async reset mid-operation. READ_LATENCY=4; assert rst between clock edges 1 cycle into WAIT -> ack, dataout and fault go to 0 immediately; ready=1; no ack follows; a subsequent read of the same address works normally.
5. With MEM_BOUNDS_CHECK_EN, DEPTH=2048:
   - Write addr 2048 datain 0x1 -> ack=1, fault=1; RAM[0] is unchanged.
   - Read addr 3000 -> dataout=0, fault=1.
   - Without the macro, the same write lands in RAM[0] and fault=0.
6. Throughput. 16 alternating write/read requests at READ_LATENCY=1 -> 16 ack pulses in 16 consecutive cycles; all read data matches the preceding writes.
